dm_copy_engine: RTL

//  Block-transfer master in front of the DM data memory: copies LEN bytes from SRC to DST,
//  or fills LEN bytes at DST with a constant. Owns the DM port (address, write_data,
//  mem_write, mem_read) while busy. Takes a single start pulse from the control FSM and

---
 rtl/dm_pkg.sv | 19 +
 rtl/dm_copy_engine.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the DM block-transfer engine: default widths,
// FSM state encoding and the transfer-mode constants.
package dm_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READ   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_WRITE  = 3'd3,
        ST_FINISH = 3'd4
    } dm_state_t;

endpackage

// File: rtl/dm_copy_engine.sv
// Block-transfer master for the DM data memory. Copies (read/wait/write per
// byte) or fills (one write per byte) an ascending, wrapping address range.
// All DM-facing outputs and the busy/done handshake come straight from flops;
// the next-cycle values are derived from the next FSM state.
module dm_copy_engine
    import dm_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int RD_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mode,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] length,
    input  logic [DW-1:0] fill_value,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] dm_address,
    output logic [DW-1:0] dm_write_data,
    output logic          dm_mem_write,
    output logic          dm_mem_read,
    input  logic [DW-1:0] dm_read_data
);

    dm_state_t     state_r, state_s;
    logic [AW-1:0] sp_r, sp_s;
    logic [AW-1:0] dp_r, dp_s;
    logic [AW-1:0] rem_r, rem_s;
    logic [1:0]    wcnt_r, wcnt_s;
    logic [DW-1:0] buf_r, buf_s;
    logic [DW-1:0] fill_r, fill_s;
    logic          mode_r, mode_s;

    logic          rd_s, wr_s, busy_s, done_s;
    logic [AW-1:0] addr_s;
    logic [DW-1:0] wdata_s;

    // Next-state, datapath updates and next-cycle DM/handshake outputs.
    always_comb begin
        state_s = state_r;
        sp_s    = sp_r;
        dp_s    = dp_r;
        rem_s   = rem_r;
        wcnt_s  = wcnt_r;
        buf_s   = buf_r;
        fill_s  = fill_r;
        mode_s  = mode_r;

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    mode_s = mode;
                    sp_s   = src_addr;
                    dp_s   = dst_addr;
                    rem_s  = length;
                    fill_s = fill_value;
                    if (length == {AW{1'b0}}) begin
                        state_s = ST_FINISH;
                    end else if (mode == MODE_FILL) begin
                        state_s = ST_WRITE;
                    end else begin
                        state_s = ST_READ;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_READ: begin
                wcnt_s  = 2'(RD_LATENCY);
                state_s = ST_WAIT;
            end
            ST_WAIT: begin
                // The read data is valid exactly on the last wait cycle.
                if (wcnt_r <= 2'd1) begin
                    buf_s   = dm_read_data;
                    wcnt_s  = 2'd0;
                    state_s = ST_WRITE;
                end else begin
                    wcnt_s  = wcnt_r - 2'd1;
                end
            end
            ST_WRITE: begin
                sp_s  = sp_r + AW'(1);
                dp_s  = dp_r + AW'(1);
                rem_s = rem_r - AW'(1);
                if (rem_r == AW'(1)) begin
                    state_s = ST_FINISH;
                end else if (mode_r == MODE_FILL) begin
                    state_s = ST_WRITE;
                end else begin
                    state_s = ST_READ;
                end
            end
            ST_FINISH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // Outputs for the coming cycle follow the state being entered, so the
        // pointers used are the already-updated ones.
        rd_s   = (state_s == ST_READ);
        wr_s   = (state_s == ST_WRITE);
        done_s = (state_s == ST_FINISH);
        busy_s = (state_s == ST_READ) || (state_s == ST_WAIT) || (state_s == ST_WRITE);

        if (rd_s) begin
            addr_s = sp_s;
        end else if (wr_s) begin
            addr_s = dp_s;
        end else begin
            addr_s = dm_address;
        end

        if (wr_s) begin
            wdata_s = (mode_s == MODE_FILL) ? fill_s : buf_s;
        end else begin
            wdata_s = dm_write_data;
        end
    end

    // State, datapath and registered-output update; reset aborts immediately.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            sp_r          <= {AW{1'b0}};
            dp_r          <= {AW{1'b0}};
            rem_r         <= {AW{1'b0}};
            wcnt_r        <= 2'd0;
            buf_r         <= {DW{1'b0}};
            fill_r        <= {DW{1'b0}};
            mode_r        <= MODE_COPY;
            busy          <= 1'b0;
            done          <= 1'b0;
            dm_mem_read   <= 1'b0;
            dm_mem_write  <= 1'b0;
            dm_address    <= {AW{1'b0}};
            dm_write_data <= {DW{1'b0}};
        end else begin
            state_r       <= state_s;
            sp_r          <= sp_s;
            dp_r          <= dp_s;
            rem_r         <= rem_s;
            wcnt_r        <= wcnt_s;
            buf_r         <= buf_s;
            fill_r        <= fill_s;
            mode_r        <= mode_s;
            busy          <= busy_s;
            done          <= done_s;
            dm_mem_read   <= rd_s;
            dm_mem_write  <= wr_s;
            dm_address    <= addr_s;
            dm_write_data <= wdata_s;
        end
    end

endmodule
